// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Purpose:
//   Debounces a raw asynchronous level input (button, slow control line).
//   The input first crosses into the clk domain through a two-flop
//   synchronizer. A four-state FSM then accepts a new level only after it
//   has been seen on DEBOUNCE_CYCLES+1 consecutive post-sync edges: the
//   entry edge plus DEBOUNCE_CYCLES pending edges. A pending transition that
//   sees the old level again is aborted and counted in a saturating glitch
//   counter.
//
// Parameters:
//   DEBOUNCE_CYCLES  pending edges required to accept a new level (1..255)
//   GLITCH_W         width of the aborted-transition counter
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset, clears all state
//   din         in   raw asynchronous level, may bounce
//   dout        out  registered debounced level
//   rise        out  one-cycle pulse with dout 0->1
//   fall        out  one-cycle pulse with dout 1->0
//   busy        out  high while a transition is pending
//   glitch_cnt  out  saturating count of aborted pending transitions
// -----------------------------------------------------------------------------
module debounce_sync #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                din,
   output logic                dout,
   output logic                rise,
   output logic                fall,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   // Counter just wide enough to hold DEBOUNCE_CYCLES.
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   // Last pending count before acceptance; the pending state is entered
   // with cnt=0, so DEBOUNCE_CYCLES pending edges end at this value.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Synchronizer
   // ---------------------------------------------------------------------------
   logic sync1_q;
   logic sync2_q;
   logic s;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
      end
   end

   // Only the second flop feeds the FSM; sync1_q may be metastable.
   assign s = sync2_q;

   // ---------------------------------------------------------------------------
   // FSM and output registers
   // ---------------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q,   cnt_d;
   logic                dout_q,  dout_d;
   logic                rise_q,  rise_d;
   logic                fall_q,  fall_d;
   logic                busy_q,  busy_d;
   logic [GLITCH_W-1:0] glitch_q, glitch_d;
   logic [GLITCH_W-1:0] glitch_inc;

   // Saturating increment: an abort at full scale leaves the count alone.
   assign glitch_inc = (glitch_q == GLITCH_MAX) ? glitch_q
                                                : glitch_q + GLITCH_W'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      glitch_d = glitch_q;

      unique case (state_q)
         STABLE_LO: begin
            if (s) begin
               state_d = PEND_HI;
               cnt_d   = '0;
            end
         end

         PEND_HI: begin
            if (!s) begin
               // Bounced back before acceptance.
               state_d  = STABLE_LO;
               cnt_d    = '0;
               glitch_d = glitch_inc;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               dout_d  = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         STABLE_HI: begin
            if (!s) begin
               state_d = PEND_LO;
               cnt_d   = '0;
            end
         end

         PEND_LO: begin
            if (s) begin
               state_d  = STABLE_HI;
               cnt_d    = '0;
               glitch_d = glitch_inc;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               dout_d  = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase

      // busy is registered from the next state so it lines up with state_q.
      busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= STABLE_LO;
         cnt_q    <= '0;
         dout_q   <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         busy_q   <= 1'b0;
         glitch_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         busy_q   <= busy_d;
         glitch_q <= glitch_d;
      end
   end

   assign dout       = dout_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign busy       = busy_q;
   assign glitch_cnt = glitch_q;

   // ---------------------------------------------------------------------------
   // Structural properties
   // ---------------------------------------------------------------------------
   a_no_dual_pulse: assert property (@(posedge clk) disable iff (!reset)
      !(rise_q && fall_q));

   a_rise_tracks_dout: assert property (@(posedge clk) disable iff (!reset)
      rise_q |-> dout_q);

   a_fall_tracks_dout: assert property (@(posedge clk) disable iff (!reset)
      fall_q |-> !dout_q);

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//
// Two instances share din/reset: DEBOUNCE_CYCLES=4/GLITCH_W=8 and the
// boundary DEBOUNCE_CYCLES=1/GLITCH_W=2. A run-length model (how many
// consecutive post-sync edges the synchronized input has disagreed with the
// accepted level) predicts every output and is compared on each falling
// edge. Directed scenarios add hand-computed literal expectations for the
// 4-cycle instance.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

   logic clk = 1'b0;
   logic reset;
   logic din;

   logic       dout0, rise0, fall0, busy0;
   logic [7:0] gc0;
   logic       dout1, rise1, fall1, busy1;
   logic [1:0] gc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   debounce_sync #(.DEBOUNCE_CYCLES(4), .GLITCH_W(8)) u_dut0 (
      .clk(clk), .reset(reset), .din(din),
      .dout(dout0), .rise(rise0), .fall(fall0), .busy(busy0), .glitch_cnt(gc0)
   );

   debounce_sync #(.DEBOUNCE_CYCLES(1), .GLITCH_W(2)) u_dut1 (
      .clk(clk), .reset(reset), .din(din),
      .dout(dout1), .rise(rise1), .fall(fall1), .busy(busy1), .glitch_cnt(gc1)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Model: s is din as sampled two edges earlier. run counts consecutive
   // edges where s differs from the accepted level; reaching D+1 accepts,
   // falling back to the accepted level with run>0 is a glitch.
   // ---------------------------------------------------------------------------
   int D_M  [2] = '{4, 1};
   int GMAX [2] = '{255, 3};

   logic h1, h2;
   int   m_run    [2];
   int   m_glitch [2];
   logic m_dout   [2];
   logic m_rise   [2];
   logic m_fall   [2];

   always @(posedge clk or negedge reset) begin : model
      int r;
      if (!reset) begin
         h1 <= 1'b0;
         h2 <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_run[i] <= 0; m_glitch[i] <= 0;
            m_dout[i] <= 1'b0; m_rise[i] <= 1'b0; m_fall[i] <= 1'b0;
         end
      end else begin
         h1 <= din;
         h2 <= h1;
         for (int i = 0; i < 2; i++) begin
            r = m_run[i];
            m_rise[i] <= 1'b0;
            m_fall[i] <= 1'b0;
            if (h2 != m_dout[i]) begin
               r = r + 1;
               if (r == D_M[i] + 1) begin
                  m_dout[i] <= h2;
                  m_rise[i] <= h2;
                  m_fall[i] <= !h2;
                  r = 0;
               end
            end else begin
               if (r > 0 && m_glitch[i] < GMAX[i]) m_glitch[i] <= m_glitch[i] + 1;
               r = 0;
            end
            m_run[i] <= r;
         end
      end
   end

   // Compare process: every falling edge, both instances.
   always @(negedge clk) begin
      check("i0.dout",   int'(dout0), int'(m_dout[0]));
      check("i0.rise",   int'(rise0), int'(m_rise[0]));
      check("i0.fall",   int'(fall0), int'(m_fall[0]));
      check("i0.busy",   int'(busy0), int'(m_run[0] != 0));
      check("i0.glitch", int'(gc0),   m_glitch[0]);
      check("i1.dout",   int'(dout1), int'(m_dout[1]));
      check("i1.rise",   int'(rise1), int'(m_rise[1]));
      check("i1.fall",   int'(fall1), int'(m_fall[1]));
      check("i1.busy",   int'(busy1), int'(m_run[1] != 0));
      check("i1.glitch", int'(gc1),   m_glitch[1]);
   end

   // Monitor for instance 0: cumulative event counts sampled 1 ns after
   // each rising edge; scenarios take deltas of these.
   int   edge_no  = 0;
   int   rise_tot = 0;
   int   fall_tot = 0;
   int   busy_tot = 0;
   int   dout_chg = 0;
   logic dout_prev = 1'b0;

   always @(posedge clk) begin
      #1;
      edge_no++;
      rise_tot += int'(rise0);
      fall_tot += int'(fall0);
      busy_tot += int'(busy0);
      if (dout0 !== dout_prev) dout_chg = edge_no;
      dout_prev = dout0;
   end

   // Advance n rising edges; returns 2 ns after the last one.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      din   = 1'b0;
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(3);
   endtask

   int e0, r0, f0, b0;

   initial begin
      reset = 1'b0;
      din   = 1'b1;

      // Reset held with din=1: everything reads zero.
      #7;
      check("rst.dout",   int'(dout0), 0);
      check("rst.rise",   int'(rise0), 0);
      check("rst.fall",   int'(fall0), 0);
      check("rst.busy",   int'(busy0), 0);
      check("rst.glitch", int'(gc0),   0);

      // Release at 10 ns. Edge A (first sync1 sample) is the next edge,
      // e0+1; acceptance at A+2+4 = e0+7.
      #3;
      reset = 1'b1;
      e0 = edge_no; r0 = rise_tot;
      cyc(10);
      check("rel.dout_edge", dout_chg - e0, 7);
      check("rel.rise_cnt",  rise_tot - r0, 1);
      check("rel.dout",      int'(dout0),   1);

      // Clean STABLE_LO, din held 1: busy for 4 cycles, one rise.
      do_reset();
      din = 1'b1;
      e0 = edge_no; r0 = rise_tot; b0 = busy_tot;
      cyc(10);
      check("up.busy_cycles", busy_tot - b0, 4);
      check("up.rise_cnt",    rise_tot - r0, 1);
      check("up.dout_edge",   dout_chg - e0, 7);
      check("up.glitch",      int'(gc0),     0);

      // Falling from STABLE_HI, din held 0.
      din = 1'b0;
      e0 = edge_no; r0 = rise_tot; f0 = fall_tot;
      cyc(10);
      check("dn.fall_cnt",  fall_tot - f0, 1);
      check("dn.rise_cnt",  rise_tot - r0, 0);
      check("dn.dout_edge", dout_chg - e0, 7);
      check("dn.dout",      int'(dout0),   0);

      // Bounce 1,0,1,0 at 20 ns each, then hold 1.
      r0 = rise_tot; f0 = fall_tot;
      din = 1'b1; cyc(2);
      din = 1'b0; cyc(2);
      din = 1'b1; cyc(2);
      din = 1'b0; cyc(2);
      check("bnc.dout_mid", int'(dout0), 0);
      din = 1'b1; cyc(10);
      check("bnc.glitch",   int'(gc0),     2);
      check("bnc.rise_cnt", rise_tot - r0, 1);
      check("bnc.fall_cnt", fall_tot - f0, 0);
      check("bnc.dout",     int'(dout0),   1);

      // 3 ns reset pulse while PEND_HI with cnt=2 (edge 5 after din rises).
      do_reset();
      din = 1'b1;
      cyc(5);
      check("pend.busy", int'(busy0), 1);
      #1 reset = 1'b0;
      #1;
      check("arst.dout",   int'(dout0), 0);
      check("arst.rise",   int'(rise0), 0);
      check("arst.fall",   int'(fall0), 0);
      check("arst.busy",   int'(busy0), 0);
      check("arst.glitch", int'(gc0),   0);
      #2 reset = 1'b1;
      r0 = rise_tot;
      cyc(3);
      check("arst.no_rise", rise_tot - r0, 0);
      check("arst.glitch2", int'(gc0),     0);
      cyc(8);

      // 300 forced aborts: one-cycle high pulses on a low line.
      do_reset();
      r0 = rise_tot;
      for (int i = 0; i < 300; i++) begin
         din = 1'b1; cyc(1);
         din = 1'b0; cyc(1);
         if (i == 99) begin
            cyc(3);
            check("sat.glitch100", int'(gc0), 100);
         end
      end
      cyc(3);
      check("sat.glitch0",   int'(gc0),     255);
      check("sat.glitch1",   int'(gc1),     3);
      check("sat.dout",      int'(dout0),   0);
      check("sat.rise_cnt",  rise_tot - r0, 0);

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
